// File: rtl/addr8s_redundant_sched.sv
// Time-redundant scheduler sharing one external 8-bit signed adder; optional 2-of-3 vote via ADDR8S_SCHED_VOTE_EN.
// Response 4 cycles after accept (+3 per retry), held until rsp_ready; no new grant until the response is taken.
module addr8s_redundant_sched #(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  input  logic [8:0]        add_sum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [8:0]        rsp_sum,
  output logic              rsp_err,
  output logic [2:0]        rsp_retries
);

`ifdef ADDR8S_SCHED_VOTE_EN
  typedef enum logic [2:0] {IDLE, EXEC1, EXEC2, EXEC3, CMP, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC1, EXEC2, CMP, RESP} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] id_q, id_d;
  logic [2:0] retry_q, retry_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [8:0] s1_q, s1_d, s2_q, s2_d;
  logic [8:0] sum_q, sum_d;
  logic       err_q, err_d;
`ifdef ADDR8S_SCHED_VOTE_EN
  logic [8:0] s3_q, s3_d;
`endif

  logic [2:0] grant, pick_hi, pick_lo;
  logic       hit_hi;
  logic [7:0] grant_a, grant_b;

  // Round-robin: lowest valid index at or above rr_ptr, else wrap to the lowest valid overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hit_hi  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_lo = 3'(i);
        if (3'(i) >= rr_ptr_q) begin
          pick_hi = 3'(i);
          hit_hi  = 1'b1;
        end
      end
    end
    grant   = hit_hi ? pick_hi : pick_lo;
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == grant) begin
        grant_a = req_a[8*i +: 8];
        grant_b = req_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      retry_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
`ifdef ADDR8S_SCHED_VOTE_EN
      s3_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      retry_q  <= retry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
`ifdef ADDR8S_SCHED_VOTE_EN
      s3_q     <= s3_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    retry_d   = retry_q;
    a_d       = a_q;
    b_d       = b_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    sum_d     = sum_q;
    err_d     = err_q;
`ifdef ADDR8S_SCHED_VOTE_EN
    s3_d      = s3_q;
`endif
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (3'(i) == grant);
          end
          id_d    = grant;
          a_d     = grant_a;
          b_d     = grant_b;
          retry_d = '0;
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        add_a   = a_q;
        add_b   = b_q;
        s1_d    = add_sum;
        state_d = EXEC2;
      end
      EXEC2: begin
        // Swapped operands exercise different adder input paths for the same sum.
        add_a   = b_q;
        add_b   = a_q;
        s2_d    = add_sum;
`ifdef ADDR8S_SCHED_VOTE_EN
        state_d = (add_sum != s1_q) ? EXEC3 : CMP;
`else
        state_d = CMP;
`endif
      end
`ifdef ADDR8S_SCHED_VOTE_EN
      EXEC3: begin
        add_a   = a_q;
        add_b   = b_q;
        s3_d    = add_sum;
        state_d = CMP;
      end
`endif
      CMP: begin
        if (s1_q == s2_q) begin
          sum_d   = s1_q;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef ADDR8S_SCHED_VOTE_EN
        else if (s1_q == s3_q) begin
          sum_d   = s1_q;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (s2_q == s3_q) begin
          sum_d   = s2_q;
          err_d   = 1'b0;
          state_d = RESP;
        end
`endif
        else if (retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          state_d = EXEC1;
        end else begin
          sum_d   = s1_q;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_sum     = sum_q;
  assign rsp_err     = err_q;
  assign rsp_retries = retry_q;

endmodule

// File: tb/tb_addr8s_redundant_sched.sv
// Bench for addr8s_redundant_sched: vector table, fault-injecting adder, round-robin, reset and random phases.
module tb_addr8s_redundant_sched;
  localparam int NREQ      = 4;
  localparam int MAX_RETRY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        add_a, add_b;
  logic [8:0]        add_sum;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [2:0]        rsp_id, rsp_retries;
  logic [8:0]        rsp_sum;
  logic              rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       flip_arm  = 1'b0;
  logic       flip_used = 1'b0;
  logic       stuck_en  = 1'b0;
  logic [7:0] flip_a    = '0;
  logic [7:0] flip_b    = '0;
  logic [7:0] eff_b;

  addr8s_redundant_sched #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_err(rsp_err), .rsp_retries(rsp_retries)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External adder with optional one-shot bit0 flip on a given operand pair and stuck-at-1 on B[3].
  always_comb begin
    eff_b = add_b;
    if (stuck_en) eff_b[3] = 1'b1;
    add_sum = {add_a[7], add_a} + {eff_b[7], eff_b};
    if (flip_arm && !flip_used && add_a == flip_a && add_b == flip_b) add_sum[0] = ~add_sum[0];
  end

  always @(posedge clk) begin
    if (!flip_arm) flip_used <= 1'b0;
    else if (add_a == flip_a && add_b == flip_b) flip_used <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return s[8:0];
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_one(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp_sum, input logic exp_err, input logic [2:0] exp_ret,
                         input int exp_lat, input bit chk_bus);
    int t_acc;
    bit got;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = NREQ'(1 << id);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (req_ready != '0);
    end
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    t_acc = cyc;
    @(posedge clk); #1;
    req_valid = '0;
    req_a = $urandom;
    req_b = $urandom;
    if (!got) return;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (chk_bus && k == 1) begin
        check({tag, "_exec1_a"}, 32'(add_a), 32'(a));
        check({tag, "_exec1_b"}, 32'(add_b), 32'(b));
      end
      if (chk_bus && k == 2) begin
        check({tag, "_exec2_a"}, 32'(add_a), 32'(b));
        check({tag, "_exec2_b"}, 32'(add_b), 32'(a));
      end
      if (chk_bus && k == 3) check({tag, "_cmp_bus"}, {add_a, add_b}, 32'h0);
      got = rsp_valid;
    end
    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc - t_acc), 32'(exp_lat));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_retries"}, 32'(rsp_retries), 32'(exp_ret));
    @(negedge clk);
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
  } vec_t;
  vec_t vecs[7];

  int         g_id[5], g_cyc[5], r_id[5];
  logic [8:0] r_sum[5];
  int         ng, nr;
  int         ptr_m, t_acc_m, exp_id;
  bit         busy, got;
  logic [8:0] exp_sum_m;
  logic [NREQ-1:0] exp_rdy;

  initial begin
    vecs[0] = '{0, 8'h7F, 8'h01, 9'h080};
    vecs[1] = '{2, 8'h80, 8'hFF, 9'h17F};
    vecs[2] = '{1, 8'h00, 8'h00, 9'h000};
    vecs[3] = '{3, 8'h7F, 8'h7F, 9'h0FE};
    vecs[4] = '{1, 8'h80, 8'h80, 9'h100};
    vecs[5] = '{3, 8'hFF, 8'h01, 9'h000};
    vecs[6] = '{0, 8'h40, 8'hC8, 9'h008};

    reset_dut();
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_add_bus", {add_a, add_b}, 32'h0);
    check("reset_rsp_fields", {rsp_id, rsp_sum, rsp_err, rsp_retries}, 32'h0);

    // All requesters valid continuously: round-robin from index 0, one grant per 5 cycles.
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_a = 32'h31211101;
    req_b = 32'h02020202;
    req_valid = '1;
    ng = 0;
    nr = 0;
    for (int n = 0; n < 60 && ng < 5; n++) begin
      @(negedge clk);
      if (rsp_valid && nr < 5) begin
        r_id[nr]  = int'(rsp_id);
        r_sum[nr] = rsp_sum;
        nr++;
      end
      if (req_ready != '0) begin
        g_id[ng]  = onehot_idx(req_ready);
        g_cyc[ng] = cyc;
        ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("rr_grant_count", 32'(ng), 32'd5);
    check("rr_rsp_count", 32'(nr), 32'd4);
    for (int k = 0; k < ng; k++) check("rr_grant_order", 32'(g_id[k]), 32'(k % NREQ));
    for (int k = 1; k < ng; k++) check("rr_grant_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd5);
    for (int k = 0; k < nr; k++) begin
      check("rr_rsp_id", 32'(r_id[k]), 32'(k));
      check("rr_rsp_sum", 32'(r_sum[k]), 32'(model_sum(req_a[8*k +: 8], 8'h02)));
    end
    repeat (10) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_one($sformatf("vec%0d", v), vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sum, 1'b0, 3'd0, 4, 1'b1);
    end

    flip_a = 8'h10;
    flip_b = 8'h20;
    flip_arm = 1'b1;
`ifdef ADDR8S_SCHED_VOTE_EN
    run_one("flip", 1, 8'h10, 8'h20, 9'h030, 1'b0, 3'd0, 5, 1'b0);
`else
    run_one("flip", 1, 8'h10, 8'h20, 9'h030, 1'b0, 3'd1, 7, 1'b0);
`endif
    flip_arm = 1'b0;

    stuck_en = 1'b1;
`ifdef ADDR8S_SCHED_VOTE_EN
    run_one("stuck", 2, 8'h08, 8'h00, 9'h010, 1'b0, 3'd0, 5, 1'b0);
`else
    run_one("stuck", 2, 8'h08, 8'h00, 9'h010, 1'b1, 3'd2, 10, 1'b0);
`endif
    stuck_en = 1'b0;

    // Response held with rsp_ready low, then reset during RESP; pointer must return to 0.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    req_a[31:24] = 8'h11;
    req_b[31:24] = 8'h22;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (req_ready != '0);
    end
    check("hold_grant", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    check("hold_rsp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("hold_stable", {rsp_valid, rsp_id, rsp_sum, rsp_err, rsp_retries}, {1'b1, 3'd3, 9'h033, 1'b0, 3'd0});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b1010;
    req_a[15:8] = 8'h05;
    req_b[15:8] = 8'h06;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_fields", {rsp_sum, rsp_err, rsp_retries}, 32'h0);
    check("post_rst_grant", 32'(req_ready), 32'h2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    check("post_rst_rsp", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 3'd1, 9'h00B});
    repeat (3) @(negedge clk);

    // Random traffic against a cycle-level reference of the arbitration and response rules.
    reset_dut();
    ptr_m = 0;
    busy  = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      req_a = $urandom;
      req_b = $urandom;
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!busy) begin
        check("rnd_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_id  = model_grant(req_valid, ptr_m);
        exp_rdy = (exp_id >= 0) ? NREQ'(1 << exp_id) : '0;
        check("rnd_grant", 32'(req_ready), 32'(exp_rdy));
        if (exp_id >= 0) begin
          busy      = 1'b1;
          t_acc_m   = cyc;
          exp_sum_m = model_sum(req_a[8*exp_id +: 8], req_b[8*exp_id +: 8]);
        end
      end else begin
        check("rnd_busy_no_grant", 32'(req_ready), 32'd0);
        if (cyc - t_acc_m < 4) begin
          check("rnd_early_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          check("rnd_rsp", {rsp_valid, rsp_id, rsp_sum, rsp_err, rsp_retries},
                {1'b1, 3'(exp_id), exp_sum_m, 1'b0, 3'd0});
          if (rsp_ready) begin
            busy  = 1'b0;
            ptr_m = (exp_id + 1) % NREQ;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr8s_redundant_sched.md
Name: addr8s_redundant_sched

Overview:
- Time-redundant scheduler that shares one external combinational 8-bit signed adder (A[7:0], B[7:0] -> O[8:0]) among NREQ requesters.
- Each accepted request runs twice on the adder: pass 1 with (A,B), pass 2 with operands swapped (B,A). The two sums are compared; mismatches are retried and persistent mismatch is flagged.
- Sits between requester ports and any addr8s_* datapath instance, adding fault detection at the system level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_RETRY, 2, re-executions allowed after a mismatch before reporting an error (0..7).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_a  input  8*NREQ  signed operand A; slice i = [8*i+7:8*i]
- req_b  input  8*NREQ  signed operand B, same slicing
- req_ready  output  NREQ  one-hot accept pulse
- add_a  output  8  to adder A input
- add_b  output  8  to adder B input
- add_sum  input  9  from adder O[8:0], combinational from add_a/add_b
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed
- rsp_id  output  3  index of the serviced requester
- rsp_sum  output  9  signed 9-bit sum
- rsp_err  output  1  mismatch persisted after MAX_RETRY retries
- rsp_retries  output  3  retries used for this response

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; retry_cnt=0; captured sums cleared.
- States: IDLE, EXEC1, EXEC2, CMP, RESP.
- IDLE, any req_valid high:
  - Grant the first valid index at or after rr_ptr, searching upward mod NREQ.
  - Assert req_ready[grant] for exactly that cycle.
  - Latch A, B and the grant id; retry_cnt=0; go to EXEC1.
  - Requester transfer completes on req_valid & req_ready in the same cycle.
- EXEC1: add_a=A, add_b=B; register s1=add_sum at the clock edge; go to EXEC2.
- EXEC2: add_a=B, add_b=A; register s2=add_sum; go to CMP.
- CMP, add_a/add_b=0:
  - s1==s2: go to RESP, rsp_sum=s1, rsp_err=0.
  - Mismatch and retry_cnt<MAX_RETRY: retry_cnt+1, go to EXEC1.
  - Mismatch and retry_cnt==MAX_RETRY: go to RESP, rsp_sum=s1, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_err/rsp_retries held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0 next cycle; rr_ptr=(grant+1) mod NREQ; go to IDLE.
- add_a/add_b are 0 in IDLE, CMP and RESP, to minimise adder toggling.
- Latency: accept at cycle T gives rsp_valid at T+4 with no retries, plus 3 cycles per retry.
- Throughput with rsp_ready tied high: one request per 5 cycles.
- No new grant until the response handshake completes.
- Arithmetic: no overflow possible; the 9-bit result is the full two's-complement sum. The block itself never computes the sum; it only compares adder outputs.
- Simultaneous requests: only one is granted; the others keep req_valid high and wait.
- req_valid dropped before grant: no effect. Operands are captured only at grant.
- Reset mid-operation: in-flight request dropped, no response, all state to reset values on the next edge.
- rsp_ready high outside RESP is ignored.

Optional Feature:
- Macro ADDR8S_SCHED_VOTE_EN.
- Defined:
  - Add EXEC3, entered after EXEC2 only when s1!=s2. It drives (A,B), captures s3, then goes to CMP.
  - CMP outputs the 2-of-3 majority with rsp_err=0 when a majority exists. With no majority it follows the retry rules above.
  - rsp_retries counts only full retries.
  - Latency with mismatch is +1 cycle before the vote.
- Not defined: two-pass compare-and-retry only; no EXEC3 state or logic.

Test Plan:
- Single request, id 0, A=0x7F, B=0x01, ideal adder: req_ready[0] pulse at T, rsp_valid at T+4, rsp_sum=9'h080, rsp_err=0, rsp_retries=0.
- id 2, A=0x80, B=0xFF: rsp_sum=9'h17F (-129), rsp_id=2; add_a/add_b show 80/FF in EXEC1 and FF/80 in EXEC2.
- All 4 valid continuously, rsp_ready=1: grant order 0,1,2,3,0, one grant every 5 cycles; rsp_id sequence matches.
- Bench adder corrupts pass 1 once (bit0 flip), A=0x10, B=0x20: rsp_sum=9'h030, rsp_retries=1, rsp_err=0, rsp_valid at T+7. With VOTE_EN: rsp_retries=0, rsp_valid at T+5.
- Bench adder stuck-at on add_b[3] only, A=0x08, B=0x00, MAX_RETRY=2: rsp_err=1, rsp_retries=2, rsp_valid at T+10.
- rsp_ready held low 6 cycles, then rst pulsed during RESP: outputs stable while waiting; after reset rsp_valid=0, rr_ptr=0, and the next grant goes to the lowest valid index.
